// File: rtl/des_sbox_pkg.sv
// Shared types and constants for the time-shared DES S-box sequencer.
// Holds the FSM state encoding, S-box geometry and the row/column address helper.
package des_sbox_pkg;

    localparam int NUM_SBOX   = 8;
    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] box_idx_t;

    // Table address is row*16 + col, with row = outer bits and col = inner four bits.
    function automatic logic [5:0] sbox_addr(input logic [5:0] chunk);
        return {chunk[5], chunk[0], chunk[4:1]};
    endfunction

endpackage

// File: rtl/sbox_seq_ctrl_if.sv
// Request/result handshake bundle between a producer/consumer and sbox_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface sbox_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/sbox_bank.sv
// Combinational bank of the eight standard DES S-boxes behind one shared lookup port.
// Each table is 64 nibbles, entry 0 in the most significant nibble.
module sbox_bank
    import des_sbox_pkg::*;
(
    input  logic [SBOX_IN_W-1:0]  chunk,
    input  box_idx_t              sel,
    output logic [SBOX_OUT_W-1:0] value
);

    localparam logic [255:0] SBOX_TAB [NUM_SBOX] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic [7:0]            shamt;
    logic [SBOX_OUT_W-1:0] lut [NUM_SBOX];

    // Entry n sits 4*n bits below the top nibble; shift it down to bit 0.
    assign shamt = 8'd252 - {sbox_addr(chunk), 2'b00};

    generate
        for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_box
            assign lut[gi] = SBOX_OUT_W'(SBOX_TAB[gi] >> shamt);
        end
    endgenerate

    assign value = lut[sel];

endmodule

// File: rtl/sbox_seq_ctrl.sv
// DES f-function substitution sequencer: one S-box lookup per cycle through a shared
// sbox_bank, eight cycles per 48-bit word, result held in DONE until handed off.
module sbox_seq_ctrl
    import des_sbox_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    sbox_seq_ctrl_if.slave  bus
);

    state_t                state_reg;
    box_idx_t              idx_reg;
    logic [47:0]           in_reg;
    logic [31:0]           result_reg;
    logic [31:0]           result_next;
    logic [SBOX_IN_W-1:0]  chunk;
    logic [SBOX_OUT_W-1:0] sbox_val;
    logic                  accept;

    // Box k reads in_reg[47-6k -: 6]; shifting right by 42-6k lands it at bit 0.
    assign chunk = SBOX_IN_W'(in_reg >> (6'd42 - 6'(idx_reg) * 6'd6));

    sbox_bank u_sbox_bank (
        .chunk (chunk),
        .sel   (idx_reg),
        .value (sbox_val)
    );

    always_comb begin
        result_next = result_reg;
        for (int i = 0; i < NUM_SBOX; i++) begin
            if (idx_reg == box_idx_t'(i)) begin
                result_next[31 - SBOX_OUT_W*i -: SBOX_OUT_W] = sbox_val;
            end
        end
    end

    // DONE hands off and re-accepts in the same cycle, so in_ready follows out_ready there.
    assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.out_data  = (state_reg == DONE) ? result_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            in_reg     <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_reg    <= bus.in_data;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    idx_reg    <= idx_reg + 3'd1;
                    if (idx_reg == box_idx_t'(NUM_SBOX - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        in_reg    <= bus.in_data;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end else if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Directed bench for sbox_seq_ctrl: known DES substitution vectors, latency,
// backpressure, back-to-back handoff and mid-run reset.
module tb_sbox_seq_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sbox_seq_ctrl_if bus ();

    sbox_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE, check latency/busy/result, optionally hold in DONE.
    task automatic do_req(input logic [47:0] d, input logic [31:0] exp, input string tag,
                          input int hold, input bit scramble);
        int lat;
        int busy_n;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk({tag, " in_ready idle"}, 48'(bus.in_ready), 48'd1);
        tick();
        bus.in_valid = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy) busy_n++;
            if (scramble) begin
                bus.in_valid = 1'($urandom);
                bus.in_data  = 48'({$urandom, $urandom});
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        #1;
        chk({tag, " latency"}, 48'(lat), 48'd9);
        chk({tag, " busy cycles"}, 48'(busy_n), 48'd8);
        chk({tag, " out_data"}, 48'(bus.out_data), 48'(exp));
        chk({tag, " in_ready done"}, 48'(bus.in_ready), 48'd0);
        $display("req %-8s in=%h out=%h lat=%0d busy=%0d", tag, d, bus.out_data, lat, busy_n);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, " hold valid"}, 48'(bus.out_valid), 48'd1);
            chk({tag, " hold data"}, 48'(bus.out_data), 48'(exp));
            chk({tag, " hold in_ready"}, 48'(bus.in_ready), 48'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk({tag, " in_ready release"}, 48'(bus.in_ready), 48'd1);
        tick();
        chk({tag, " idle valid"}, 48'(bus.out_valid), 48'd0);
        chk({tag, " idle data"}, 48'(bus.out_data), 48'd0);
        chk({tag, " idle busy"}, 48'(bus.busy), 48'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst in_ready", 48'(bus.in_ready), 48'd1);
        chk("rst out_valid", 48'(bus.out_valid), 48'd0);
        chk("rst out_data", 48'(bus.out_data), 48'd0);
        chk("rst busy", 48'(bus.busy), 48'd0);

        // Reset wins over a simultaneous request.
        bus.in_valid = 1'b1;
        bus.in_data  = 48'h123456789ABC;
        tick();
        chk("rst prio busy", 48'(bus.busy), 48'd0);
        chk("rst prio in_ready", 48'(bus.in_ready), 48'd1);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        tick();

        do_req(48'h000000000000, 32'hEFA72C4D, "zero", 0, 1'b0);
        do_req(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones", 0, 1'b0);
        do_req(48'h6117BA866527, 32'h5C82B597, "round1", 0, 1'b1);
        do_req(48'hAAAAAAAAAAAA, 32'h64FBD83C, "aaaa", 0, 1'b1);
        do_req(48'h555555555555, 32'hC152FD56, "bkpr", 5, 1'b0);

        // Back-to-back: second request taken in the DONE cycle of the first.
        bus.in_data   = 48'h0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_data = 48'hFFFFFFFFFFFF;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b first latency", 48'(lat), 48'd9);
        chk("b2b first data", 48'(bus.out_data), 48'hEFA72C4D);
        chk("b2b in_ready", 48'(bus.in_ready), 48'd1);
        $display("req b2b-1    out=%h lat=%0d", bus.out_data, lat);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b rerun busy", 48'(bus.busy), 48'd1);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b second spacing", 48'(lat), 48'd9);
        chk("b2b second data", 48'(bus.out_data), 48'hD9CE3DCB);
        $display("req b2b-2    out=%h lat=%0d", bus.out_data, lat);
        tick();
        chk("b2b idle valid", 48'(bus.out_valid), 48'd0);
        bus.out_ready = 1'b0;

        // Abort at box index 4 with a synchronous reset.
        bus.in_data  = 48'h6117BA866527;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort busy before", 48'(bus.busy), 48'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 48'(bus.in_ready), 48'd1);
        chk("abort out_valid", 48'(bus.out_valid), 48'd0);
        chk("abort out_data", 48'(bus.out_data), 48'd0);
        chk("abort busy", 48'(bus.busy), 48'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("abort no output", 48'(bus.out_valid), 48'd0);
        $display("req abort    reset at index 4");
        do_req(48'h000000000000, 32'hEFA72C4D, "postrst", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
